// File: rtl/tl_a_rr_arbiter_pkg.sv
// Shared TileLink definitions for the A-channel round-robin arbiter:
// opcode constants, channel field widths, arbiter states and the burst beat-count decode.
package tl_a_rr_arbiter_pkg;

    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_GET         = 3'd4;

    localparam int unsigned TL_OPCODE_W     = 3;
    localparam int unsigned TL_A_PARAM_W    = 3;
    localparam int unsigned TL_D_PARAM_W    = 2;
    localparam int unsigned TL_SIZE_W       = 3;
    localparam int unsigned TL_IN_SOURCE_W  = 2;
    localparam int unsigned TL_OUT_SOURCE_W = 3;
    localparam int unsigned TL_ADDR_W       = 31;
    localparam int unsigned TL_MASK_W       = 8;
    localparam int unsigned TL_DATA_W       = 64;
    localparam int unsigned TL_SINK_W       = 1;
    localparam int unsigned TL_BEAT_W       = 4;
    localparam int unsigned TL_CNT_W        = 3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Beats carried by a request on the 64-bit bus; only Puts larger than one
    // bus word span multiple beats, and the count saturates at max_beats.
    function automatic logic [TL_BEAT_W-1:0] tl_beats(
        input logic [TL_OPCODE_W-1:0] opcode,
        input logic [TL_SIZE_W-1:0]   size,
        input int unsigned            max_beats
    );
        int unsigned n;
        n = 1;
        if ((opcode == TL_PUT_FULL || opcode == TL_PUT_PARTIAL) && size > 3'd3) begin
            n = 32'd1 << (size - 3'd3);
            if (n > max_beats) begin
                n = max_beats;
            end
        end
        return TL_BEAT_W'(n);
    endfunction

endpackage

// File: rtl/tl_a_rr_arbiter_beat_counter.sv
// Burst beat tracking: decodes the beat count of the granted request, holds the
// remaining-beat counter and flags the beat that ends the current request.
module tl_beat_counter
    import tl_a_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [TL_OPCODE_W-1:0] a_opcode,
    input  logic [TL_SIZE_W-1:0]   a_size,
    input  logic                   fire,
    input  logic                   locked,
    output logic                   last_beat
);

    logic [TL_BEAT_W-1:0] beats;
    logic [TL_CNT_W-1:0]  beat_cnt;

    assign beats     = tl_beats(a_opcode, a_size, MAX_BEATS);
    // An unlocked fire is the first beat, so it is also the last only for single-beat requests.
    assign last_beat = locked ? (beat_cnt == TL_CNT_W'(1)) : (beats == TL_BEAT_W'(1));

    // Load remaining beats on the first fire of a burst, count down on each locked fire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
        end else if (fire) begin
            if (locked) begin
                beat_cnt <= beat_cnt - 1'b1;
            end else if (!last_beat) begin
                beat_cnt <= TL_CNT_W'(beats - 1'b1);
            end
        end
    end

endmodule

// File: rtl/tl_a_rr_arbiter.sv
// Two-port TileLink A-channel round-robin arbiter with burst locking, plus
// zero-latency D-channel response routing by the source MSB.
module tl_a_rr_arbiter
    import tl_a_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IN    = 2,
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       in0_a_valid,
    output logic                       in0_a_ready,
    input  logic [TL_OPCODE_W-1:0]     in0_a_bits_opcode,
    input  logic [TL_A_PARAM_W-1:0]    in0_a_bits_param,
    input  logic [TL_SIZE_W-1:0]       in0_a_bits_size,
    input  logic [TL_IN_SOURCE_W-1:0]  in0_a_bits_source,
    input  logic [TL_ADDR_W-1:0]       in0_a_bits_address,
    input  logic [TL_MASK_W-1:0]       in0_a_bits_mask,
    input  logic [TL_DATA_W-1:0]       in0_a_bits_data,
    input  logic                       in0_a_bits_corrupt,

    input  logic                       in1_a_valid,
    output logic                       in1_a_ready,
    input  logic [TL_OPCODE_W-1:0]     in1_a_bits_opcode,
    input  logic [TL_A_PARAM_W-1:0]    in1_a_bits_param,
    input  logic [TL_SIZE_W-1:0]       in1_a_bits_size,
    input  logic [TL_IN_SOURCE_W-1:0]  in1_a_bits_source,
    input  logic [TL_ADDR_W-1:0]       in1_a_bits_address,
    input  logic [TL_MASK_W-1:0]       in1_a_bits_mask,
    input  logic [TL_DATA_W-1:0]       in1_a_bits_data,
    input  logic                       in1_a_bits_corrupt,

    input  logic                       in0_d_ready,
    output logic                       in0_d_valid,
    output logic [TL_OPCODE_W-1:0]     in0_d_bits_opcode,
    output logic [TL_D_PARAM_W-1:0]    in0_d_bits_param,
    output logic [TL_SIZE_W-1:0]       in0_d_bits_size,
    output logic [TL_IN_SOURCE_W-1:0]  in0_d_bits_source,
    output logic [TL_SINK_W-1:0]       in0_d_bits_sink,
    output logic                       in0_d_bits_denied,
    output logic [TL_DATA_W-1:0]       in0_d_bits_data,
    output logic                       in0_d_bits_corrupt,

    input  logic                       in1_d_ready,
    output logic                       in1_d_valid,
    output logic [TL_OPCODE_W-1:0]     in1_d_bits_opcode,
    output logic [TL_D_PARAM_W-1:0]    in1_d_bits_param,
    output logic [TL_SIZE_W-1:0]       in1_d_bits_size,
    output logic [TL_IN_SOURCE_W-1:0]  in1_d_bits_source,
    output logic [TL_SINK_W-1:0]       in1_d_bits_sink,
    output logic                       in1_d_bits_denied,
    output logic [TL_DATA_W-1:0]       in1_d_bits_data,
    output logic                       in1_d_bits_corrupt,

    output logic                       out_a_valid,
    input  logic                       out_a_ready,
    output logic [TL_OPCODE_W-1:0]     out_a_bits_opcode,
    output logic [TL_A_PARAM_W-1:0]    out_a_bits_param,
    output logic [TL_SIZE_W-1:0]       out_a_bits_size,
    output logic [TL_OUT_SOURCE_W-1:0] out_a_bits_source,
    output logic [TL_ADDR_W-1:0]       out_a_bits_address,
    output logic [TL_MASK_W-1:0]       out_a_bits_mask,
    output logic [TL_DATA_W-1:0]       out_a_bits_data,
    output logic                       out_a_bits_corrupt,

    input  logic                       out_d_valid,
    output logic                       out_d_ready,
    input  logic [TL_OPCODE_W-1:0]     out_d_bits_opcode,
    input  logic [TL_D_PARAM_W-1:0]    out_d_bits_param,
    input  logic [TL_SIZE_W-1:0]       out_d_bits_size,
    input  logic [TL_OUT_SOURCE_W-1:0] out_d_bits_source,
    input  logic [TL_SINK_W-1:0]       out_d_bits_sink,
    input  logic                       out_d_bits_denied,
    input  logic [TL_DATA_W-1:0]       out_d_bits_data,
    input  logic                       out_d_bits_corrupt
);

    localparam int unsigned PORT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    arb_state_e          state_q, state_d;
    logic [PORT_W-1:0]   grant, lock_port, rr_last;
    logic                locked, arb_active, sel1, fire, last_beat;
    logic [TL_IN_SOURCE_W-1:0] sel_source;

    assign locked = (state_q == ST_LOCKED);

    // Grant selection: held on the locked port, otherwise round-robin among valid ports.
    always_comb begin
        grant      = '0;
        arb_active = locked || in0_a_valid || in1_a_valid;
        if (locked) begin
            grant = lock_port;
        end else if (in0_a_valid && in1_a_valid) begin
            grant = ~rr_last;
        end else if (in1_a_valid) begin
            grant = PORT_W'(1);
        end
    end

    // A-channel mux toward the output; with nothing valid it shows port 0 with no ready.
    always_comb begin
        sel1               = (grant == PORT_W'(1));
        out_a_valid        = sel1 ? in1_a_valid        : in0_a_valid;
        out_a_bits_opcode  = sel1 ? in1_a_bits_opcode  : in0_a_bits_opcode;
        out_a_bits_param   = sel1 ? in1_a_bits_param   : in0_a_bits_param;
        out_a_bits_size    = sel1 ? in1_a_bits_size    : in0_a_bits_size;
        sel_source         = sel1 ? in1_a_bits_source  : in0_a_bits_source;
        out_a_bits_address = sel1 ? in1_a_bits_address : in0_a_bits_address;
        out_a_bits_mask    = sel1 ? in1_a_bits_mask    : in0_a_bits_mask;
        out_a_bits_data    = sel1 ? in1_a_bits_data    : in0_a_bits_data;
        out_a_bits_corrupt = sel1 ? in1_a_bits_corrupt : in0_a_bits_corrupt;
        out_a_bits_source  = {grant, sel_source};
        in0_a_ready        = arb_active && !sel1 && out_a_ready;
        in1_a_ready        = arb_active &&  sel1 && out_a_ready;
        fire               = out_a_valid && out_a_ready;
    end

    tl_beat_counter #(
        .MAX_BEATS (MAX_BEATS)
    ) u_beat_counter (
        .clock     (clock),
        .reset     (reset),
        .a_opcode  (out_a_bits_opcode),
        .a_size    (out_a_bits_size),
        .fire      (fire),
        .locked    (locked),
        .last_beat (last_beat)
    );

    // Next state: lock on the first beat of a multi-beat burst, unlock on its last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fire && !last_beat) state_d = ST_LOCKED;
            ST_LOCKED: if (fire &&  last_beat) state_d = ST_IDLE;
        endcase
    end

    // State, locked port and round-robin history registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            lock_port <= '0;
            rr_last   <= PORT_W'(1);
        end else begin
            state_q <= state_d;
            if (fire && !locked && !last_beat) begin
                lock_port <= grant;
            end
            if (fire && last_beat) begin
                rr_last <= grant;
            end
        end
    end

    // D-channel routing by source MSB, independent of arbitration state.
    always_comb begin
        in0_d_valid        = out_d_valid && !out_d_bits_source[2];
        in1_d_valid        = out_d_valid &&  out_d_bits_source[2];
        in0_d_bits_opcode  = out_d_bits_opcode;
        in1_d_bits_opcode  = out_d_bits_opcode;
        in0_d_bits_param   = out_d_bits_param;
        in1_d_bits_param   = out_d_bits_param;
        in0_d_bits_size    = out_d_bits_size;
        in1_d_bits_size    = out_d_bits_size;
        in0_d_bits_source  = out_d_bits_source[1:0];
        in1_d_bits_source  = out_d_bits_source[1:0];
        in0_d_bits_sink    = out_d_bits_sink;
        in1_d_bits_sink    = out_d_bits_sink;
        in0_d_bits_denied  = out_d_bits_denied;
        in1_d_bits_denied  = out_d_bits_denied;
        in0_d_bits_data    = out_d_bits_data;
        in1_d_bits_data    = out_d_bits_data;
        in0_d_bits_corrupt = out_d_bits_corrupt;
        in1_d_bits_corrupt = out_d_bits_corrupt;
        out_d_ready        = out_d_bits_source[2] ? in1_d_ready : in0_d_ready;
    end

endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// Self-checking bench for tl_a_rr_arbiter: table-driven single-beat arbitration
// vectors, hand-written burst/stall/reset sequences, and an A-channel fire scoreboard.
module tb_tl_a_rr_arbiter;
    import tl_a_rr_arbiter_pkg::*;

    logic clock, reset;
    logic in0_a_valid, in0_a_ready, in0_a_bits_corrupt;
    logic [2:0] in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size;
    logic [1:0] in0_a_bits_source;
    logic [30:0] in0_a_bits_address;
    logic [7:0] in0_a_bits_mask;
    logic [63:0] in0_a_bits_data;
    logic in1_a_valid, in1_a_ready, in1_a_bits_corrupt;
    logic [2:0] in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size;
    logic [1:0] in1_a_bits_source;
    logic [30:0] in1_a_bits_address;
    logic [7:0] in1_a_bits_mask;
    logic [63:0] in1_a_bits_data;
    logic in0_d_ready, in0_d_valid, in0_d_bits_denied, in0_d_bits_corrupt;
    logic [2:0] in0_d_bits_opcode, in0_d_bits_size;
    logic [1:0] in0_d_bits_param, in0_d_bits_source;
    logic [0:0] in0_d_bits_sink;
    logic [63:0] in0_d_bits_data;
    logic in1_d_ready, in1_d_valid, in1_d_bits_denied, in1_d_bits_corrupt;
    logic [2:0] in1_d_bits_opcode, in1_d_bits_size;
    logic [1:0] in1_d_bits_param, in1_d_bits_source;
    logic [0:0] in1_d_bits_sink;
    logic [63:0] in1_d_bits_data;
    logic out_a_valid, out_a_ready, out_a_bits_corrupt;
    logic [2:0] out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_source;
    logic [30:0] out_a_bits_address;
    logic [7:0] out_a_bits_mask;
    logic [63:0] out_a_bits_data;
    logic out_d_valid, out_d_ready, out_d_bits_denied, out_d_bits_corrupt;
    logic [2:0] out_d_bits_opcode, out_d_bits_size, out_d_bits_source;
    logic [1:0] out_d_bits_param;
    logic [0:0] out_d_bits_sink;
    logic [63:0] out_d_bits_data;

    tl_a_rr_arbiter #(.NUM_IN(2), .MAX_BEATS(8)) dut (
        .clock(clock), .reset(reset),
        .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready),
        .in0_a_bits_opcode(in0_a_bits_opcode), .in0_a_bits_param(in0_a_bits_param),
        .in0_a_bits_size(in0_a_bits_size), .in0_a_bits_source(in0_a_bits_source),
        .in0_a_bits_address(in0_a_bits_address), .in0_a_bits_mask(in0_a_bits_mask),
        .in0_a_bits_data(in0_a_bits_data), .in0_a_bits_corrupt(in0_a_bits_corrupt),
        .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready),
        .in1_a_bits_opcode(in1_a_bits_opcode), .in1_a_bits_param(in1_a_bits_param),
        .in1_a_bits_size(in1_a_bits_size), .in1_a_bits_source(in1_a_bits_source),
        .in1_a_bits_address(in1_a_bits_address), .in1_a_bits_mask(in1_a_bits_mask),
        .in1_a_bits_data(in1_a_bits_data), .in1_a_bits_corrupt(in1_a_bits_corrupt),
        .in0_d_ready(in0_d_ready), .in0_d_valid(in0_d_valid),
        .in0_d_bits_opcode(in0_d_bits_opcode), .in0_d_bits_param(in0_d_bits_param),
        .in0_d_bits_size(in0_d_bits_size), .in0_d_bits_source(in0_d_bits_source),
        .in0_d_bits_sink(in0_d_bits_sink), .in0_d_bits_denied(in0_d_bits_denied),
        .in0_d_bits_data(in0_d_bits_data), .in0_d_bits_corrupt(in0_d_bits_corrupt),
        .in1_d_ready(in1_d_ready), .in1_d_valid(in1_d_valid),
        .in1_d_bits_opcode(in1_d_bits_opcode), .in1_d_bits_param(in1_d_bits_param),
        .in1_d_bits_size(in1_d_bits_size), .in1_d_bits_source(in1_d_bits_source),
        .in1_d_bits_sink(in1_d_bits_sink), .in1_d_bits_denied(in1_d_bits_denied),
        .in1_d_bits_data(in1_d_bits_data), .in1_d_bits_corrupt(in1_d_bits_corrupt),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
        .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
        .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
        .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
        .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
        .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
        .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt)
    );

    typedef struct {
        logic [2:0]  source;
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [63:0] data;
    } fire_t;

    typedef struct {
        logic       v0, v1, rdy;
        logic       exp_ov;
        logic [2:0] exp_src;
        logic       exp_r0, exp_r1;
    } vec_t;

    fire_t sb[$];
    vec_t  vecs[8];
    int    checks = 0;
    int    errors = 0;
    int    fire_count = 0;
    int    fire_base;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_a(input int p, input logic v, input logic [2:0] op, input logic [2:0] sz,
                           input logic [1:0] src, input logic [63:0] d);
        if (p == 0) begin
            in0_a_valid = v; in0_a_bits_opcode = op; in0_a_bits_size = sz;
            in0_a_bits_source = src; in0_a_bits_data = d; in0_a_bits_address = d[30:0];
        end else begin
            in1_a_valid = v; in1_a_bits_opcode = op; in1_a_bits_size = sz;
            in1_a_bits_source = src; in1_a_bits_data = d; in1_a_bits_address = d[30:0];
        end
    endtask

    task automatic expect_fire(input int p, input logic [2:0] op, input logic [2:0] sz,
                               input logic [1:0] src, input logic [63:0] d);
        fire_t f;
        f.source = {(p != 0), src};
        f.opcode = op;
        f.size   = sz;
        f.data   = d;
        sb.push_back(f);
    endtask

    // Scoreboard monitor: samples mid-cycle the transfer that fires at the next rising edge.
    always @(negedge clock) begin
        fire_t f;
        #2;
        if (reset && out_a_valid && out_a_ready) begin
            fire_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_fire: got source %0h data %0h expected no fire at %0t",
                         out_a_bits_source, out_a_bits_data, $time);
            end else begin
                f = sb.pop_front();
                chk("sb_source", {61'd0, out_a_bits_source}, {61'd0, f.source});
                chk("sb_opcode", {61'd0, out_a_bits_opcode}, {61'd0, f.opcode});
                chk("sb_size",   {61'd0, out_a_bits_size},   {61'd0, f.size});
                chk("sb_data",   out_a_bits_data, f.data);
                chk("sb_address", {33'd0, out_a_bits_address}, {33'd0, f.data[30:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        in0_a_bits_param = 3'd0; in0_a_bits_mask = 8'hFF; in0_a_bits_corrupt = 1'b0;
        in1_a_bits_param = 3'd0; in1_a_bits_mask = 8'hFF; in1_a_bits_corrupt = 1'b0;
        drive_a(0, 1'b0, TL_GET, 3'd3, 2'b00, 64'd0);
        drive_a(1, 1'b0, TL_GET, 3'd3, 2'b00, 64'd0);
        out_a_ready = 1'b1;
        in0_d_ready = 1'b0; in1_d_ready = 1'b0;
        out_d_valid = 1'b0; out_d_bits_opcode = 3'd0; out_d_bits_param = 2'd0;
        out_d_bits_size = 3'd0; out_d_bits_source = 3'd0; out_d_bits_sink = 1'b0;
        out_d_bits_denied = 1'b0; out_d_bits_data = 64'd0; out_d_bits_corrupt = 1'b0;

        // v0 v1 rdy | out_valid source r0 r1 ; rr_last starts at 1 so port 0 wins the first tie
        vecs[0] = '{1, 1, 1, 1, 3'b001, 1, 0};
        vecs[1] = '{1, 1, 1, 1, 3'b110, 0, 1};
        vecs[2] = '{0, 0, 1, 0, 3'b001, 0, 0};
        vecs[3] = '{0, 1, 1, 1, 3'b110, 0, 1};
        vecs[4] = '{1, 1, 0, 1, 3'b001, 0, 0};
        vecs[5] = '{1, 1, 1, 1, 3'b001, 1, 0};
        vecs[6] = '{1, 0, 1, 1, 3'b001, 1, 0};
        vecs[7] = '{1, 1, 1, 1, 3'b110, 0, 1};

        // Reset state: nothing granted with no valid; first tie would go to port 0.
        repeat (2) @(negedge clock);
        #1;
        chk("rst_out_valid", {63'd0, out_a_valid}, 64'd0);
        chk("rst_in0_ready", {63'd0, in0_a_ready}, 64'd0);
        chk("rst_in1_ready", {63'd0, in1_a_ready}, 64'd0);
        drive_a(0, 1'b1, TL_GET, 3'd3, 2'b00, 64'h1);
        drive_a(1, 1'b1, TL_GET, 3'd3, 2'b00, 64'h2);
        #1;
        chk("rst_tie_grant", {63'd0, out_a_bits_source[2]}, 64'd0);

        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            out_a_ready = vecs[i].rdy;
            drive_a(0, vecs[i].v0, TL_GET, 3'd3, 2'b01, 64'h0A00 + 64'(i));
            drive_a(1, vecs[i].v1, TL_GET, 3'd3, 2'b10, 64'h0B00 + 64'(i));
            if (vecs[i].exp_ov && vecs[i].rdy)
                expect_fire(vecs[i].exp_src[2] ? 1 : 0, TL_GET, 3'd3, vecs[i].exp_src[1:0],
                            vecs[i].exp_src[2] ? 64'h0B00 + 64'(i) : 64'h0A00 + 64'(i));
            #1;
            chk("vec_out_valid", {63'd0, out_a_valid}, {63'd0, vecs[i].exp_ov});
            chk("vec_source", {61'd0, out_a_bits_source}, {61'd0, vecs[i].exp_src});
            chk("vec_in0_ready", {63'd0, in0_a_ready}, {63'd0, vecs[i].exp_r0});
            chk("vec_in1_ready", {63'd0, in1_a_ready}, {63'd0, vecs[i].exp_r1});
            @(negedge clock);
        end
        out_a_ready = 1'b1;

        // 8-beat PutFull on port 1 while port 0 keeps requesting.
        drive_a(0, 1'b1, TL_GET, 3'd3, 2'b00, 64'h1000);
        drive_a(1, 1'b0, TL_GET, 3'd3, 2'b00, 64'h0);
        expect_fire(0, TL_GET, 3'd3, 2'b00, 64'h1000);
        @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            drive_a(0, 1'b1, TL_GET, 3'd3, 2'b11, 64'h2000);
            drive_a(1, 1'b1, TL_PUT_FULL, 3'd6, 2'b01, 64'h3000 + 64'(k));
            expect_fire(1, TL_PUT_FULL, 3'd6, 2'b01, 64'h3000 + 64'(k));
            #1;
            chk("burst8_in0_ready", {63'd0, in0_a_ready}, 64'd0);
            chk("burst8_grant", {63'd0, out_a_bits_source[2]}, 64'd1);
            @(negedge clock);
        end
        drive_a(1, 1'b0, TL_GET, 3'd3, 2'b00, 64'h0);
        expect_fire(0, TL_GET, 3'd3, 2'b11, 64'h2000);
        #1;
        chk("burst8_cycle9_in0_ready", {63'd0, in0_a_ready}, 64'd1);
        @(negedge clock);

        // 4-beat Put on port 0: valid gap and a 5-cycle stall mid-burst.
        fire_base = fire_count;
        drive_a(0, 1'b1, TL_PUT_FULL, 3'd5, 2'b10, 64'h4000);
        expect_fire(0, TL_PUT_FULL, 3'd5, 2'b10, 64'h4000);
        @(negedge clock);
        drive_a(0, 1'b1, TL_PUT_FULL, 3'd5, 2'b10, 64'h4001);
        drive_a(1, 1'b1, TL_GET, 3'd3, 2'b00, 64'h5000);
        expect_fire(0, TL_PUT_FULL, 3'd5, 2'b10, 64'h4001);
        #1;
        chk("burst4_in1_ready", {63'd0, in1_a_ready}, 64'd0);
        @(negedge clock);
        drive_a(0, 1'b0, TL_PUT_FULL, 3'd5, 2'b10, 64'h4002);
        #1;
        chk("gap_out_valid", {63'd0, out_a_valid}, 64'd0);
        chk("gap_in0_ready", {63'd0, in0_a_ready}, 64'd1);
        chk("gap_in1_ready", {63'd0, in1_a_ready}, 64'd0);
        @(negedge clock);
        out_a_ready = 1'b0;
        drive_a(0, 1'b1, TL_PUT_FULL, 3'd5, 2'b10, 64'h4002);
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_out_valid", {63'd0, out_a_valid}, 64'd1);
            chk("stall_grant", {63'd0, out_a_bits_source[2]}, 64'd0);
            chk("stall_in0_ready", {63'd0, in0_a_ready}, 64'd0);
            @(negedge clock);
        end
        out_a_ready = 1'b1;
        expect_fire(0, TL_PUT_FULL, 3'd5, 2'b10, 64'h4002);
        @(negedge clock);
        drive_a(0, 1'b1, TL_PUT_FULL, 3'd5, 2'b10, 64'h4003);
        expect_fire(0, TL_PUT_FULL, 3'd5, 2'b10, 64'h4003);
        @(negedge clock);
        chk("burst4_fire_count", 64'(fire_count - fire_base), 64'd4);
        drive_a(0, 1'b0, TL_GET, 3'd3, 2'b00, 64'h0);
        expect_fire(1, TL_GET, 3'd3, 2'b00, 64'h5000);
        #1;
        chk("after_burst4_in1_ready", {63'd0, in1_a_ready}, 64'd1);
        @(negedge clock);

        // PutPartial size 7 saturates at 8 beats, then arbitration is open again.
        for (int k = 0; k < 8; k++) begin
            drive_a(1, 1'b1, TL_PUT_PARTIAL, 3'd7, 2'b11, 64'h6000 + 64'(k));
            expect_fire(1, TL_PUT_PARTIAL, 3'd7, 2'b11, 64'h6000 + 64'(k));
            @(negedge clock);
        end
        drive_a(0, 1'b1, TL_GET, 3'd3, 2'b01, 64'h6100);
        drive_a(1, 1'b1, TL_GET, 3'd3, 2'b01, 64'h6200);
        expect_fire(0, TL_GET, 3'd3, 2'b01, 64'h6100);
        #1;
        chk("pp7_idle_grant", {63'd0, out_a_bits_source[2]}, 64'd0);
        @(negedge clock);

        // Reset after beat 2 of an 8-beat Put on port 1.
        drive_a(0, 1'b0, TL_GET, 3'd3, 2'b00, 64'h0);
        for (int k = 0; k < 2; k++) begin
            drive_a(1, 1'b1, TL_PUT_FULL, 3'd6, 2'b10, 64'h7000 + 64'(k));
            expect_fire(1, TL_PUT_FULL, 3'd6, 2'b10, 64'h7000 + 64'(k));
            @(negedge clock);
        end
        reset = 1'b0;
        drive_a(1, 1'b0, TL_GET, 3'd3, 2'b00, 64'h0);
        #1;
        chk("midrst_out_valid", {63'd0, out_a_valid}, 64'd0);
        chk("midrst_in1_ready", {63'd0, in1_a_ready}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        drive_a(0, 1'b1, TL_GET, 3'd3, 2'b00, 64'h7100);
        drive_a(1, 1'b1, TL_GET, 3'd3, 2'b01, 64'h7200);
        expect_fire(0, TL_GET, 3'd3, 2'b00, 64'h7100);
        #1;
        chk("postrst_grant", {63'd0, out_a_bits_source[2]}, 64'd0);
        @(negedge clock);
        expect_fire(1, TL_GET, 3'd3, 2'b01, 64'h7200);
        #1;
        chk("postrst_get_unlocked", {63'd0, out_a_bits_source[2]}, 64'd1);
        chk("postrst_in1_ready", {63'd0, in1_a_ready}, 64'd1);
        @(negedge clock);
        drive_a(0, 1'b0, TL_GET, 3'd3, 2'b00, 64'h0);
        drive_a(1, 1'b0, TL_GET, 3'd3, 2'b00, 64'h0);

        // D routing by source MSB.
        out_d_valid = 1'b1; out_d_bits_source = 3'b110; out_d_bits_opcode = 3'd1;
        out_d_bits_data = 64'hDEAD_BEEF_0123_4567; out_d_bits_sink = 1'b1; out_d_bits_denied = 1'b1;
        in0_d_ready = 1'b0; in1_d_ready = 1'b1;
        #1;
        chk("d_in1_valid", {63'd0, in1_d_valid}, 64'd1);
        chk("d_in1_source", {62'd0, in1_d_bits_source}, 64'd2);
        chk("d_in0_valid", {63'd0, in0_d_valid}, 64'd0);
        chk("d_ready_in1", {63'd0, out_d_ready}, 64'd1);
        chk("d_in1_data", in1_d_bits_data, 64'hDEAD_BEEF_0123_4567);
        chk("d_in1_opcode", {61'd0, in1_d_bits_opcode}, 64'd1);
        chk("d_in1_sink_denied", {62'd0, in1_d_bits_sink, in1_d_bits_denied}, 64'd3);
        in1_d_ready = 1'b0; in0_d_ready = 1'b1;
        #1;
        chk("d_ready_in1_low", {63'd0, out_d_ready}, 64'd0);
        out_d_bits_source = 3'b011;
        #1;
        chk("d_in0_valid_port0", {63'd0, in0_d_valid}, 64'd1);
        chk("d_in1_valid_port0", {63'd0, in1_d_valid}, 64'd0);
        chk("d_in0_source", {62'd0, in0_d_bits_source}, 64'd3);
        chk("d_ready_in0", {63'd0, out_d_ready}, 64'd1);
        out_d_valid = 1'b0;

        @(negedge clock);
        @(negedge clock);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
